// File: rtl/key_event.sv
// key_event: turns the filtered key level into coded press events.
//   SHORT (1) on release before LONG_CYC high samples, LONG (2) on the
//   LONG_CYC-th consecutive high sample, optional REPEAT (3) while held.
//   Events leave through a one-deep valid/ready register; a sticky ovf
//   flag records any event dropped while the register was full.
// Optional feature macro: KEY_REPEAT_EN (enables REPEAT events).
// Ports:
//   clk       clock, all registers on posedge
//   rst       asynchronous reset, active-high
//   i         filtered key level, 1 = pressed
//   ev_valid  event pending
//   ev_code   1 = SHORT, 2 = LONG, 3 = REPEAT
//   ev_ready  consumer accepts when ev_valid && ev_ready
//   pressed   1 while the FSM is outside IDLE
//   ovf       sticky event-dropped flag
//   ovf_clr   clears ovf (a same-cycle set wins)
module key_event #(
  parameter int unsigned LONG_CYC   = 8,
  parameter int unsigned REPEAT_CYC = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i,
  output logic       ev_valid,
  output logic [1:0] ev_code,
  input  logic       ev_ready,
  output logic       pressed,
  output logic       ovf,
  input  logic       ovf_clr
);

  localparam int unsigned CODE_W = 2;
  localparam logic [CODE_W-1:0] CODE_SHORT  = CODE_W'(1);
  localparam logic [CODE_W-1:0] CODE_LONG   = CODE_W'(2);
  localparam logic [CNT_W-1:0]  LONG_LAST   = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_ALL1    = '1;
`ifdef KEY_REPEAT_EN
  localparam logic [CODE_W-1:0] CODE_REPEAT = CODE_W'(3);
  localparam logic [CNT_W-1:0]  REP_LAST    = CNT_W'(REPEAT_CYC - 1);
`endif

  // Elaboration-time parameter sanity check
  if (REPEAT_CYC < 1 || LONG_CYC < 2 || LONG_CYC > (2**CNT_W) - 1) begin : g_bad_cfg
    $error("key_event: illegal LONG_CYC/REPEAT_CYC/CNT_W combination");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ev_valid;
  logic [CODE_W-1:0]   r_ev_code;
  logic                r_pressed;
  logic                r_ovf;

  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_det;
  logic [CODE_W-1:0]   w_det_code;

  // Next state, hold counter and event detection for the current sample
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_det       = 1'b0;
    w_det_code  = CODE_SHORT;
    case (r_state)
      IDLE: begin
        if (i) begin
          w_state_nxt = PRESS;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      PRESS: begin
        if (!i) begin
          w_det       = 1'b1;
          w_det_code  = CODE_SHORT;
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LONG_LAST) begin
          w_det       = 1'b1;
          w_det_code  = CODE_LONG;
          w_state_nxt = HOLD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!i) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
`ifdef KEY_REPEAT_EN
          if (r_cnt == REP_LAST) begin
            w_det      = 1'b1;
            w_det_code = CODE_REPEAT;
            w_cnt_nxt  = '0;
          end else
`endif
          if (r_cnt != CNT_ALL1) w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // FSM state, counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_ev_valid <= 1'b0;
      r_ev_code  <= '0;
      r_pressed  <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pressed <= (w_state_nxt != IDLE);
      // A full register that is being drained this cycle can take a new event
      if (w_det) begin
        if (!r_ev_valid || ev_ready) begin
          r_ev_valid <= 1'b1;
          r_ev_code  <= w_det_code;
        end
      end else if (r_ev_valid && ev_ready) begin
        r_ev_valid <= 1'b0;
      end
      // Drop wins over a simultaneous clear
      if (w_det && r_ev_valid && !ev_ready) r_ovf <= 1'b1;
      else if (ovf_clr)                     r_ovf <= 1'b0;
    end
  end

  assign ev_valid = r_ev_valid;
  assign ev_code  = r_ev_code;
  assign pressed  = r_pressed;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_key_event.sv
// Scoreboard bench for key_event: random and directed key activity is fed
// to a reference model that reasons in terms of "number of consecutive high
// samples", and a monitor compares every post-edge DUT state and every
// accepted event against the model's queued expectations.
module tb_key_event;

  localparam int LONG_CYC   = 8;
  localparam int REPEAT_CYC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       i;
  logic       ev_valid;
  logic [1:0] ev_code;
  logic       ev_ready;
  logic       pressed;
  logic       ovf;
  logic       ovf_clr;

  key_event #(.LONG_CYC(LONG_CYC), .REPEAT_CYC(REPEAT_CYC), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .i(i), .ev_valid(ev_valid), .ev_code(ev_code),
    .ev_ready(ev_ready), .pressed(pressed), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic [1:0] code;
    logic       ovf;
    logic       pressed;
  } snap_t;

  snap_t snap_q[$];
  int    exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int   run;
  logic m_valid;
  int   m_code;
  logic m_ovf;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    run     = 0;
    m_valid = 1'b0;
    m_code  = 0;
    m_ovf   = 1'b0;
  endtask

  // One sampled edge: event from the consecutive-high count, then output register rules
  task automatic model_step(input logic vi, input logic vr, input logic vc);
    int   ev;
    logic set;
    snap_t s;
    ev  = 0;
    set = 1'b0;
    if (vi) begin
      run++;
      if (run == LONG_CYC) ev = 2;
`ifdef KEY_REPEAT_EN
      else if (run > LONG_CYC && ((run - LONG_CYC) % REPEAT_CYC) == 0) ev = 3;
`endif
    end else begin
      if (run > 0 && run < LONG_CYC) ev = 1;
      run = 0;
    end
    if (ev != 0) begin
      if (!m_valid || vr) begin
        m_valid = 1'b1;
        m_code  = ev;
        exp_q.push_back(ev);
      end else begin
        set = 1'b1;
      end
    end else if (m_valid && vr) begin
      m_valid = 1'b0;
    end
    if (set)     m_ovf = 1'b1;
    else if (vc) m_ovf = 1'b0;
    s.valid   = m_valid;
    s.code    = 2'(m_code);
    s.ovf     = m_ovf;
    s.pressed = (run > 0);
    snap_q.push_back(s);
  endtask

  // Drive inputs for the next edge and advance the model
  task automatic cyc(input logic vi, input logic vr, input logic vc);
    @(posedge clk);
    #1;
    i        = vi;
    ev_ready = vr;
    ovf_clr  = vc;
    model_step(vi, vr, vc);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ev_valid"}, int'(ev_valid), 0);
    check({tag, "_ev_code"},  int'(ev_code),  0);
    check({tag, "_pressed"},  int'(pressed),  0);
    check({tag, "_ovf"},      int'(ovf),      0);
  endtask

  task automatic release_reset();
    snap_t s;
    @(posedge clk);
    #1;
    rst = 1'b0;
    s = '0;
    snap_q.push_back(s);
    model_step(i, ev_ready, ovf_clr);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock edge
  task automatic reset_mid();
    @(posedge clk);
    #3;
    rst = 1'b1;
    snap_q.delete();
    exp_q.delete();
    model_reset();
    #1;
    check_zero_outputs("async_rst");
    repeat (2) @(posedge clk);
  endtask

  // Monitor: post-edge state compare and handshake scoreboard
  always @(negedge clk) begin
    snap_t s;
    int    e;
    if (!rst && snap_q.size() > 0) begin
      s = snap_q.pop_front();
      check("ev_valid", int'(ev_valid), int'(s.valid));
      check("ev_code",  int'(ev_code),  int'(s.code));
      check("ovf",      int'(ovf),      int'(s.ovf));
      check("pressed",  int'(pressed),  int'(s.pressed));
      if (ev_valid && ev_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", int'(ev_code), 0);
        end else begin
          e = exp_q.pop_front();
          check("accepted_code", int'(ev_code), e);
        end
      end
    end
  end

  function automatic logic rnd_ready(input int mode);
    case (mode)
      0:       return 1'b1;
      1:       return 1'($urandom % 2);
      default: return 1'(($urandom % 4) != 0);
    endcase
  endfunction

  initial begin
    int mode, hl, ll;
    rst      = 1'b1;
    i        = 1'b0;
    ev_ready = 1'b1;
    ovf_clr  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    release_reset();

    // Short press of 3 samples
    repeat (3) cyc(1'b1, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, 1'b1, 1'b0);

    // Long hold of 20 samples then release
    repeat (20) cyc(1'b1, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, 1'b1, 1'b0);

    // Exactly LONG_CYC samples: LONG only
    repeat (LONG_CYC) cyc(1'b1, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, 1'b1, 1'b0);

    // LONG_CYC-1 samples: SHORT
    repeat (LONG_CYC - 1) cyc(1'b1, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, 1'b1, 1'b0);

    // Stalled consumer: second short press dropped, ovf set, then drain and clear
    for (int k = 0; k < 2; k++) begin
      repeat (2) cyc(1'b1, 1'b0, 1'b0);
      repeat (2) cyc(1'b0, 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);

    // Drop and clear on the same edge: set wins
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    repeat (2) cyc(1'b0, 1'b1, 1'b1);

    // Accept and load on the same edge
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    repeat (2) cyc(1'b0, 1'b1, 1'b0);

    // Reset while in PRESS with count 5, key low afterwards
    repeat (5) cyc(1'b1, 1'b1, 1'b0);
    reset_mid();
    i = 1'b0;
    release_reset();
    repeat (4) cyc(1'b0, 1'b1, 1'b0);

    // Reset with key held: counts as a fresh press
    repeat (3) cyc(1'b1, 1'b1, 1'b0);
    reset_mid();
    release_reset();
    repeat (LONG_CYC + 2) cyc(1'b1, 1'b1, 1'b0);
    repeat (2) cyc(1'b0, 1'b1, 1'b0);

    // Randomized key activity
    for (int seg = 0; seg < 300; seg++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset_mid();
        release_reset();
      end
      mode = int'($urandom % 3);
      hl   = int'($urandom_range(1, 22));
      ll   = int'($urandom_range(1, 4));
      for (int k = 0; k < hl; k++)
        cyc(1'b1, rnd_ready(mode), 1'($urandom_range(0, 7) == 0));
      for (int k = 0; k < ll; k++)
        cyc(1'b0, rnd_ready(mode), 1'($urandom_range(0, 7) == 0));
    end

    // Drain and confirm every expected event was accepted
    repeat (6) cyc(1'b0, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("events_left", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
